// File: rtl/bcd_digit_entry.sv
// Three-digit decimal entry: debounced inc/next buttons edit hundreds, tens and
// ones, then the digits are converted to a saturating 8-bit binary value.

module bcd_digit_entry_btn #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic [7:0] cnt_q,   cnt_d;

  // The flip happens on the edge where the count would reach DEBOUNCE_CYCLES,
  // so the press pulse is registered together with the new accepted level.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

module bcd_digit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_inc,
  input  logic       btn_next,
  output logic [3:0] cur_digit,
  output logic [1:0] digit_index,
  output logic       busy,
  output logic [7:0] value,
  output logic       valid,
  output logic       overflow,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIG_H,
    S_DIG_T,
    S_DIG_O,
    S_RESULT
  } state_t;

  localparam logic [3:0] BLANK = 4'd10;

  logic press_inc, press_next;

  bcd_digit_entry_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_inc),
    .press   (press_inc)
  );

  bcd_digit_entry_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_next),
    .press   (press_next)
  );

  state_t     state_q,       state_d;
  logic [3:0] dig_h_q,       dig_h_d;
  logic [3:0] dig_t_q,       dig_t_d;
  logic [3:0] dig_o_q,       dig_o_d;
  logic [3:0] cur_digit_q,   cur_digit_d;
  logic [1:0] digit_index_q, digit_index_d;
  logic       busy_q,        busy_d;
  logic [7:0] value_q,       value_d;
  logic       valid_q,       valid_d;
  logic       overflow_q,    overflow_d;
  logic       done_q,        done_d;

  logic [3:0] cur_inc;
  logic [9:0] h10, t10, o10, sum;

  assign cur_inc = (cur_digit_q == 4'd9) ? 4'd0 : cur_digit_q + 4'd1;

  // h*100 = h*64 + h*32 + h*4, t*10 = t*8 + t*2; the ones digit is live.
  assign h10 = {6'b0, dig_h_q};
  assign t10 = {6'b0, dig_t_q};
  assign o10 = {6'b0, cur_digit_q};
  assign sum = (h10 << 6) + (h10 << 5) + (h10 << 2)
             + (t10 << 3) + (t10 << 1) + o10;

  always_comb begin
    state_d       = state_q;
    dig_h_d       = dig_h_q;
    dig_t_d       = dig_t_q;
    dig_o_d       = dig_o_q;
    cur_digit_d   = cur_digit_q;
    digit_index_d = digit_index_q;
    busy_d        = busy_q;
    value_d       = value_q;
    valid_d       = valid_q;
    overflow_d    = overflow_q;
    done_d        = 1'b0;

    if (start) begin
      state_d       = S_DIG_H;
      dig_h_d       = '0;
      dig_t_d       = '0;
      dig_o_d       = '0;
      cur_digit_d   = '0;
      digit_index_d = 2'd0;
      busy_d        = 1'b1;
      value_d       = '0;
      valid_d       = 1'b0;
      overflow_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_DIG_H: begin
          if (press_next) begin
            dig_h_d       = cur_digit_q;
            cur_digit_d   = '0;
            digit_index_d = 2'd1;
            state_d       = S_DIG_T;
          end else if (press_inc) begin
            cur_digit_d = cur_inc;
          end
        end
        S_DIG_T: begin
          if (press_next) begin
            dig_t_d       = cur_digit_q;
            cur_digit_d   = '0;
            digit_index_d = 2'd2;
            state_d       = S_DIG_O;
          end else if (press_inc) begin
            cur_digit_d = cur_inc;
          end
        end
        S_DIG_O: begin
          if (press_next) begin
            dig_o_d       = cur_digit_q;
            cur_digit_d   = BLANK;
            digit_index_d = 2'd3;
            busy_d        = 1'b0;
            valid_d       = 1'b1;
            done_d        = 1'b1;
            state_d       = S_RESULT;
            if (sum[9:8] != 2'b00) begin
              value_d    = '1;
              overflow_d = 1'b1;
            end else begin
              value_d    = sum[7:0];
              overflow_d = 1'b0;
            end
          end else if (press_inc) begin
            cur_digit_d = cur_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dig_h_q       <= '0;
      dig_t_q       <= '0;
      dig_o_q       <= '0;
      cur_digit_q   <= BLANK;
      digit_index_q <= 2'd3;
      busy_q        <= 1'b0;
      value_q       <= '0;
      valid_q       <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dig_h_q       <= dig_h_d;
      dig_t_q       <= dig_t_d;
      dig_o_q       <= dig_o_d;
      cur_digit_q   <= cur_digit_d;
      digit_index_q <= digit_index_d;
      busy_q        <= busy_d;
      value_q       <= value_d;
      valid_q       <= valid_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

  assign cur_digit   = cur_digit_q;
  assign digit_index = digit_index_q;
  assign busy        = busy_q;
  assign value       = value_q;
  assign valid       = valid_q;
  assign overflow    = overflow_q;
  assign done        = done_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed bench for bcd_digit_entry: inputs are driven and outputs sampled on
// the falling edge; each press is a clean 6-sample high followed by 8 low cycles.

module tb_bcd_digit_entry;

  logic       clk, rst, start, btn_inc, btn_next;
  logic [3:0] cur_digit;
  logic [1:0] digit_index;
  logic       busy, valid, overflow, done;
  logic [7:0] value;

  int passed, failed, total, done_cnt;

  bcd_digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .btn_inc     (btn_inc),
    .btn_next    (btn_next),
    .cur_digit   (cur_digit),
    .digit_index (digit_index),
    .busy        (busy),
    .value       (value),
    .valid       (valid),
    .overflow    (overflow),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input bit do_inc, input bit do_next);
    btn_inc  = do_inc;
    btn_next = do_next;
    repeat (6) @(negedge clk);
    btn_inc  = 1'b0;
    btn_next = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
  endtask

  task automatic enter(input int h, input int t, input int o);
    for (int i = 0; i < h; i++) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    for (int i = 0; i < t; i++) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    for (int i = 0; i < o; i++) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
  endtask

  task automatic check_result(input string tag, input int v, input bit ov);
    check({tag, "_valid"}, 16'(valid), 16'd1);
    check({tag, "_value"}, 16'(value), 16'(v));
    check({tag, "_ovf"}, 16'(overflow), 16'(ov));
    check({tag, "_done_cnt"}, 16'(done_cnt), 16'd1);
  endtask

  initial begin
    passed = 0; failed = 0; total = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; btn_inc = 1'b0; btn_next = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_cur", 16'(cur_digit), 16'd10);
    check("rst_idx", 16'(digit_index), 16'd3);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_valid", 16'(valid), 16'd0);
    check("rst_ovf", 16'(overflow), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_value", 16'(value), 16'd0);

    // 1,2,8 -> 128
    pulse_start();
    check("t1_idx_h", 16'(digit_index), 16'd0);
    check("t1_cur0", 16'(cur_digit), 16'd0);
    check("t1_busy", 16'(busy), 16'd1);
    press(1'b1, 1'b0);
    check("t1_cur1", 16'(cur_digit), 16'd1);
    press(1'b0, 1'b1);
    check("t1_idx_t", 16'(digit_index), 16'd1);
    check("t1_cur_t", 16'(cur_digit), 16'd0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("t1_idx_o", 16'(digit_index), 16'd2);
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0);
    check("t1_cur8", 16'(cur_digit), 16'd8);
    check("t1_done_pre", 16'(done_cnt), 16'd0);
    press(1'b0, 1'b1);
    check_result("t1", 128, 1'b0);
    check("t1_idx_res", 16'(digit_index), 16'd3);
    check("t1_cur_res", 16'(cur_digit), 16'd10);
    check("t1_busy_res", 16'(busy), 16'd0);
    press(1'b1, 1'b0);
    check("t1_res_hold", 16'(value), 16'd128);

    // Saturation boundaries
    pulse_start();
    check("t2_start_valid", 16'(valid), 16'd0);
    check("t2_start_value", 16'(value), 16'd0);
    enter(2, 5, 5);
    check_result("t2_255", 255, 1'b0);
    pulse_start();
    check("t2_start_ovf", 16'(overflow), 16'd0);
    enter(2, 5, 6);
    check_result("t2_256", 255, 1'b1);
    pulse_start();
    enter(9, 9, 9);
    check_result("t2_999", 255, 1'b1);

    // Wrap in tens position
    pulse_start();
    press(1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      press(1'b1, 1'b0);
      check($sformatf("t3_wrap%0d", i), 16'(cur_digit), 16'(i % 10));
    end
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check_result("t3", 30, 1'b0);

    // Glitch rejection and press latency
    pulse_start();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (20) begin
      btn_inc = 1'b1;
      repeat (3) @(negedge clk);
      btn_inc = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("t4_glitch", 16'(cur_digit), 16'd2);
    btn_inc = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_lat_n4", 16'(cur_digit), 16'd2);
    @(negedge clk);
    check("t4_lat_n5", 16'(cur_digit), 16'd2);
    btn_inc = 1'b0;
    @(negedge clk);
    check("t4_lat_n6", 16'(cur_digit), 16'd3);
    repeat (8) @(negedge clk);
    check("t4_release", 16'(cur_digit), 16'd3);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check_result("t4_300", 255, 1'b1);

    // Simultaneous inc+next: next wins
    pulse_start();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
    check("t5_cur4", 16'(cur_digit), 16'd4);
    press(1'b1, 1'b1);
    check_result("t5", 124, 1'b0);
    check("t5_idx", 16'(digit_index), 16'd3);

    // Reset mid-entry, then start mid-entry
    pulse_start();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("t6_pre_idx", 16'(digit_index), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_idx", 16'(digit_index), 16'd3);
    check("t6_rst_cur", 16'(cur_digit), 16'd10);
    check("t6_rst_busy", 16'(busy), 16'd0);
    check("t6_rst_valid", 16'(valid), 16'd0);
    press(1'b1, 1'b0);
    check("t6_idle_ign", 16'(cur_digit), 16'd10);
    pulse_start();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("t6_dig_o", 16'(digit_index), 16'd2);
    pulse_start();
    check("t6_rs_idx", 16'(digit_index), 16'd0);
    check("t6_rs_cur", 16'(cur_digit), 16'd0);
    check("t6_rs_valid", 16'(valid), 16'd0);
    check("t6_rs_busy", 16'(busy), 16'd1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check_result("t6_zero", 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
